// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: memory port
// tracking, load-use detection, stall accounting and timeout flag.
module pipeline_hazard_ctrl #(
   parameter logic [5:0]  LW_ICODE   = 6'b100011,
   parameter int unsigned WAIT_LIMIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_addr_ok,
   input  logic        i_data_ok,
   input  logic        d_req,
   input  logic        d_addr_ok,
   input  logic        d_data_ok,
   input  logic [5:0]  e_icode,
   input  logic [4:0]  e_dst,
   input  logic [4:0]  d_src1,
   input  logic [4:0]  d_src2,
   input  logic        d_use1,
   input  logic        d_use2,
   output logic        F_stall,
   output logic        D_stall,
   output logic        E_stall,
   output logic        M_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        W_bubble,
   output logic [31:0] stall_cnt,
   output logic        timeout
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } port_state_t;

   localparam logic [15:0] LIMIT_M1 = 16'(WAIT_LIMIT - 1);

   port_state_t i_state;
   port_state_t d_state;
   logic        i_busy;
   logic        d_busy;
   logic        lu;
   logic        any_stall;
   logic [15:0] i_wait;
   logic [15:0] d_wait;
   logic        i_hit;
   logic        d_hit;

   // A response completes the request if the port is already waiting
   // or the address is accepted in the same cycle.
   assign i_busy = i_req & ~(i_data_ok & ((i_state == S_WAIT) | i_addr_ok));
   assign d_busy = d_req & ~(d_data_ok & ((d_state == S_WAIT) | d_addr_ok));

   assign lu = (e_icode == LW_ICODE) & (e_dst != 5'd0) &
               ((d_use1 & (d_src1 == e_dst)) |
                (d_use2 & (d_src2 == e_dst)));

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      E_stall  = 1'b0;
      M_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      W_bubble = 1'b0;
      if (!reset) begin
         if (d_busy) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
         end else if (lu) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
         end else if (i_busy) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
         end
      end
   end

   assign any_stall = F_stall | D_stall | E_stall | M_stall |
                      D_bubble | E_bubble | W_bubble;

   always_ff @(posedge clk) begin
      if (reset) begin
         i_state <= S_IDLE;
         d_state <= S_IDLE;
      end else begin
         unique case (i_state)
            S_IDLE:
               if (i_req && i_addr_ok && !i_data_ok)
                  i_state <= S_WAIT;
            S_WAIT:
               if (i_data_ok)
                  i_state <= S_IDLE;
            default: i_state <= S_IDLE;
         endcase
         unique case (d_state)
            S_IDLE:
               if (d_req && d_addr_ok && !d_data_ok)
                  d_state <= S_WAIT;
            S_WAIT:
               if (d_data_ok)
                  d_state <= S_IDLE;
            default: d_state <= S_IDLE;
         endcase
      end
   end

   assign i_hit = i_busy & (i_wait == LIMIT_M1);
   assign d_hit = d_busy & (d_wait == LIMIT_M1);

   // Wait counters hold at all-ones so a very long wait cannot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_wait    <= 16'd0;
         d_wait    <= 16'd0;
         stall_cnt <= 32'd0;
         timeout   <= 1'b0;
      end else begin
         if (!i_busy)
            i_wait <= 16'd0;
         else if (i_wait != 16'hFFFF)
            i_wait <= i_wait + 16'd1;
         if (!d_busy)
            d_wait <= 16'd0;
         else if (d_wait != 16'hFFFF)
            d_wait <= d_wait + 16'd1;
         if (any_stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (i_hit || d_hit)
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based
// scoreboard; expected values are hand-computed per cycle.
module tb_pipeline_hazard_ctrl;

   localparam logic [5:0] LW = 6'b100011;

   // {F_stall,D_stall,E_stall,M_stall,D_bubble,E_bubble,W_bubble}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] DB   = 7'b1111001;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] IB   = 7'b1000100;

   // {i_req,i_addr_ok,i_data_ok,d_req,d_addr_ok,d_data_ok}
   localparam logic [5:0] M0   = 6'b000000;
   localparam logic [5:0] IAD  = 6'b111000;
   localparam logic [5:0] IA   = 6'b110000;
   localparam logic [5:0] IR   = 6'b100000;
   localparam logic [5:0] IRD  = 6'b101000;
   localparam logic [5:0] ID   = 6'b001000;
   localparam logic [5:0] DA   = 6'b000110;
   localparam logic [5:0] DR   = 6'b000100;
   localparam logic [5:0] DRD  = 6'b000101;

   typedef struct packed {
      logic [6:0]  st;
      logic [31:0] cnt;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_addr_ok, i_data_ok;
   logic        d_req, d_addr_ok, d_data_ok;
   logic [5:0]  e_icode;
   logic [4:0]  e_dst, d_src1, d_src2;
   logic        d_use1, d_use2;
   logic        F_stall, D_stall, E_stall, M_stall;
   logic        D_bubble, E_bubble, W_bubble;
   logic [31:0] stall_cnt;
   logic        timeout;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .LW_ICODE  (LW),
      .WAIT_LIMIT(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr_ok(i_addr_ok),
      .i_data_ok(i_data_ok),
      .d_req    (d_req),
      .d_addr_ok(d_addr_ok),
      .d_data_ok(d_data_ok),
      .e_icode  (e_icode),
      .e_dst    (e_dst),
      .d_src1   (d_src1),
      .d_src2   (d_src2),
      .d_use1   (d_use1),
      .d_use2   (d_use2),
      .F_stall  (F_stall),
      .D_stall  (D_stall),
      .E_stall  (E_stall),
      .M_stall  (M_stall),
      .D_bubble (D_bubble),
      .E_bubble (E_bubble),
      .W_bubble (W_bubble),
      .stall_cnt(stall_cnt),
      .timeout  (timeout)
   );

   // Monitor: outputs are sampled mid-cycle, away from the clock edge.
   always @(negedge clk) begin
      exp_t       e;
      logic [6:0] got;
      if (q.size() > 0) begin
         e   = q.pop_front();
         got = {F_stall, D_stall, E_stall, M_stall,
                D_bubble, E_bubble, W_bubble};
         vec_no++;
         checks++;
         if (got !== e.st) begin
            errors++;
            $display("FAIL stall_vec #%0d: got %b want %b",
                     vec_no, got, e.st);
         end
         checks++;
         if (stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL stall_cnt #%0d: got %0d want %0d",
                     vec_no, stall_cnt, e.cnt);
         end
         checks++;
         if (timeout !== e.to) begin
            errors++;
            $display("FAIL timeout #%0d: got %b want %b",
                     vec_no, timeout, e.to);
         end
      end
   end

   task automatic haz(input logic [5:0] ic, input logic [4:0] dst,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2);
      e_icode = ic;
      e_dst   = dst;
      d_src1  = s1;
      d_src2  = s2;
      d_use1  = u1;
      d_use2  = u2;
   endtask

   task automatic vec(input logic rst, input logic [5:0] m,
                      input logic [6:0] st, input logic [31:0] cnt,
                      input logic to);
      exp_t e;
      reset = rst;
      {i_req, i_addr_ok, i_data_ok, d_req, d_addr_ok, d_data_ok} = m;
      e.st  = st;
      e.cnt = cnt;
      e.to  = to;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      {i_req, i_addr_ok, i_data_ok} = 3'b000;
      {d_req, d_addr_ok, d_data_ok} = 3'b000;
      haz(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // reset forces outputs low even with a busy fetch
      vec(1, IR, NONE, 0, 0);

      // single-cycle fetches never stall
      for (int k = 0; k < 10; k++)
         vec(0, IAD, NONE, 0, 0);

      // load-use hazard cases
      haz(LW, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      vec(0, M0, LU, 0, 0);
      haz(LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      vec(0, M0, NONE, 1, 0);
      haz(LW, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
      vec(0, M0, LU, 1, 0);
      haz(LW, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
      vec(0, M0, NONE, 2, 0);
      haz(6'b100000, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      vec(0, M0, NONE, 2, 0);
      haz(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

      // multi-cycle fetch
      vec(0, IA,  IB,   2, 0);
      vec(0, IR,  IB,   3, 0);
      vec(0, IR,  IB,   4, 0);
      vec(0, IRD, NONE, 5, 0);
      vec(0, M0,  NONE, 5, 0);
      // stray data_ok in IDLE is ignored
      vec(0, ID,  NONE, 5, 0);
      vec(0, IRD, IB,   5, 0);
      vec(0, IAD, NONE, 6, 0);

      // d_busy outranks lu, lu outranks i_busy
      haz(LW, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
      vec(0, DA | IR, DB, 6, 0);
      vec(0, DRD,     LU, 7, 0);
      vec(0, IR,      LU, 8, 0);
      haz(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      vec(0, M0,    NONE, 9, 0);

      // data port timeout with limit 4
      vec(0, DA,  DB,   9,  0);
      vec(0, DR,  DB,   10, 0);
      vec(0, DR,  DB,   11, 0);
      vec(0, DR,  DB,   12, 0);
      vec(0, DR,  DB,   13, 1);
      vec(0, DR,  DB,   14, 1);
      vec(0, DRD, NONE, 15, 1);
      vec(0, M0,  NONE, 15, 1);

      // reset while fetch port waits
      vec(0, IA,  IB,   15, 1);
      vec(0, IR,  IB,   16, 1);
      vec(1, IR,  NONE, 17, 1);
      vec(0, ID,  NONE, 0,  0);
      vec(0, IRD, IB,   0,  0);
      vec(0, M0,  NONE, 1,  0);

      for (int k = 0; k < 10 && q.size() > 0; k++)
         @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/bubble controller for the 5-stage MIPS pipeline (F, D, E, M, W).
- Tracks the instruction-memory and data-memory request handshakes with two small FSMs.
- Detects load-use hazards between the E and D stages, which the D-stage forwarding network cannot cover.
- Drives per-stage stall/bubble controls by fixed priority.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
LW_ICODE, 6'b100011, opcode identifying a load in E.
WAIT_LIMIT, 64, consecutive busy cycles on one port before timeout sets (legal range 1..65535).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch stage requests an instruction (level, held until data_ok).
- i_addr_ok  in  1  imem accepted address this cycle.
- i_data_ok  in  1  imem returns data this cycle.
- d_req  in  1  M stage holds a load/store (level, held until data_ok).
- d_addr_ok  in  1  dmem accepted address this cycle.
- d_data_ok  in  1  dmem returns data/ack this cycle.
- e_icode  in  6  opcode in E.
- e_dst  in  5  destination register in E.
- d_src1  in  5  rs index in D.
- d_src2  in  5  rt index in D.
- d_use1  in  1  D instruction reads d_src1.
- d_use2  in  1  D instruction reads d_src2.
- F_stall, D_stall, E_stall, M_stall  out  1 each  hold the stage register.
- D_bubble, E_bubble, W_bubble  out  1 each  load a NOP (all-zero) into the stage register.
- stall_cnt  out  32  cycles with any stall/bubble asserted.
- timeout  out  1  sticky memory-timeout flag.

Behaviour:
Port FSMs (one each for i and d; x denotes i or d):
- States: IDLE, WAIT. Reset → IDLE.
- IDLE: if x_req & x_addr_ok & ~x_data_ok → WAIT. Same-cycle addr_ok & data_ok completes the transaction; stay IDLE.
- WAIT: x_data_ok → IDLE. x_addr_ok is ignored in WAIT.
- x_data_ok in IDLE without x_addr_ok the same cycle is ignored (covers a stale response after reset).

Busy (combinational):
- x_busy = x_req & ~(x_data_ok & (state==WAIT | x_addr_ok)).

Load-use hazard (combinational):
- lu = (e_icode==LW_ICODE) & (e_dst!=0) & ((d_use1 & d_src1==e_dst) | (d_use2 & d_src2==e_dst)).

Stall/bubble outputs are combinational, same cycle. Fixed priority:
1. d_busy: F_stall = D_stall = E_stall = M_stall = 1, W_bubble = 1; all others 0.
2. else lu: F_stall = D_stall = 1, E_bubble = 1.
3. else i_busy: F_stall = 1, D_bubble = 1.
4. else all outputs 0.
- A stall and a bubble are never both asserted for the same stage.
- While reset = 1, all stall/bubble outputs are forced to 0.

Counters and flags:
- stall_cnt: +1 on every non-reset cycle where any stall/bubble output is 1; saturates at 32'hFFFFFFFF; reset → 0.
- Per-port wait counter (16 bit): increments while x_busy, clears when x_busy = 0.
- timeout is set on the edge where either wait counter reaches WAIT_LIMIT, and stays 1 until reset; reset → 0.
- Reset mid-transaction: both FSMs return to IDLE and all counters clear on that edge; in-flight responses are not tracked.

Latency:
- Stall outputs have zero-cycle latency from inputs.
- State, stall_cnt and timeout update one cycle after their cause.

Test Plan:
1. Reset, then i_req=1 with i_addr_ok=i_data_ok=1 every cycle for 10 cycles → all stalls 0, stall_cnt stays 0.
2. e_icode=LW_ICODE, e_dst=5, d_src1=5, d_use1=1 for one cycle → F_stall=D_stall=E_bubble=1 that cycle; stall_cnt=1 next cycle. Repeat with e_dst=0 → no stall.
3. i_req=1, i_addr_ok=1 at cycle 0, i_data_ok at cycle 3 → i FSM in WAIT cycles 1–3; F_stall=D_bubble=1 cycles 0–2, 0 at cycle 3; stall_cnt=3.
4. d_busy and lu asserted together → only the d_busy pattern appears (E_bubble=0, E_stall=1, W_bubble=1).
5. WAIT_LIMIT=4, d_req=1 with no d_data_ok for 6 cycles → timeout rises after the 4th busy cycle and stays 1 after d_data_ok; cleared only by reset.
6. Assert reset while the i FSM is in WAIT, then pulse i_data_ok with i_req=0 → FSM IDLE, no outputs asserted, stall_cnt=0.
